// File: rtl/dx_operand_stage.sv
// Decode-to-execute operand stage: resolves rs1/rs2 with X > M > W > RF bypassing,
// selects rs2 or immediate, and registers operands plus destination info into X.
module dx_operand_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        d_val_i,
  output logic        d_rdy_o,
  input  logic [4:0]  d_rs1_addr_i,
  input  logic [4:0]  d_rs2_addr_i,
  input  logic [31:0] d_rs1_data_i,
  input  logic [31:0] d_rs2_data_i,
  input  logic [31:0] d_imm_i,
  input  logic        d_op2_sel_i,
  input  logic        d_alu_op_i,
  input  logic [4:0]  d_rd_addr_i,
  input  logic        d_rf_wen_i,
  input  logic        x_stall_i,
  input  logic        x_squash_i,
  input  logic [31:0] x_alu_out_i,
  input  logic        m_val_i,
  input  logic        m_rf_wen_i,
  input  logic [4:0]  m_rd_addr_i,
  input  logic [31:0] m_result_i,
  input  logic        w_val_i,
  input  logic        w_rf_wen_i,
  input  logic [4:0]  w_rd_addr_i,
  input  logic [31:0] w_result_i,
  output logic        x_val_o,
  output logic [31:0] x_alu_in0_o,
  output logic [31:0] x_alu_in1_o,
  output logic        x_alu_op_o,
  output logic [4:0]  x_rd_addr_o,
  output logic        x_rf_wen_o,
  output logic [31:0] x_store_data_o
);

  logic        x_val_q, x_val_d;
  logic        x_rf_wen_q, x_rf_wen_d;
  logic        x_alu_op_q, x_alu_op_d;
  logic [4:0]  x_rd_addr_q, x_rd_addr_d;
  logic [31:0] x_alu_in0_q, x_alu_in0_d;
  logic [31:0] x_alu_in1_q, x_alu_in1_d;
  logic [31:0] x_store_data_q, x_store_data_d;

  logic        x_wr, m_wr, w_wr;
  logic [31:0] rs1_byp, rs2_byp;

  // A bubble in X has x_val_q low, so it can never produce a bypass hit.
  assign x_wr = x_val_q & x_rf_wen_q;
  assign m_wr = m_val_i & m_rf_wen_i;
  assign w_wr = w_val_i & w_rf_wen_i;

  always_comb begin
    rs1_byp = d_rs1_data_i;
    if (d_rs1_addr_i != 5'd0) begin
      if (x_wr && (x_rd_addr_q == d_rs1_addr_i)) begin
        rs1_byp = x_alu_out_i;
      end else if (m_wr && (m_rd_addr_i == d_rs1_addr_i)) begin
        rs1_byp = m_result_i;
      end else if (w_wr && (w_rd_addr_i == d_rs1_addr_i)) begin
        rs1_byp = w_result_i;
      end
    end
  end

  always_comb begin
    rs2_byp = d_rs2_data_i;
    if (d_rs2_addr_i != 5'd0) begin
      if (x_wr && (x_rd_addr_q == d_rs2_addr_i)) begin
        rs2_byp = x_alu_out_i;
      end else if (m_wr && (m_rd_addr_i == d_rs2_addr_i)) begin
        rs2_byp = m_result_i;
      end else if (w_wr && (w_rd_addr_i == d_rs2_addr_i)) begin
        rs2_byp = w_result_i;
      end
    end
  end

  always_comb begin
    x_val_d        = x_val_q;
    x_rf_wen_d     = x_rf_wen_q;
    x_alu_op_d     = x_alu_op_q;
    x_rd_addr_d    = x_rd_addr_q;
    x_alu_in0_d    = x_alu_in0_q;
    x_alu_in1_d    = x_alu_in1_q;
    x_store_data_d = x_store_data_q;
    // Stall holds everything; squash only matters once X is free to advance.
    if (!x_stall_i) begin
      if (x_squash_i || !d_val_i) begin
        x_val_d        = 1'b0;
        x_rf_wen_d     = 1'b0;
        x_alu_op_d     = 1'b0;
        x_rd_addr_d    = 5'd0;
        x_alu_in0_d    = 32'd0;
        x_alu_in1_d    = 32'd0;
        x_store_data_d = 32'd0;
      end else begin
        x_val_d        = 1'b1;
        x_rf_wen_d     = d_rf_wen_i;
        x_alu_op_d     = d_alu_op_i;
        x_rd_addr_d    = d_rd_addr_i;
        x_alu_in0_d    = rs1_byp;
        x_alu_in1_d    = d_op2_sel_i ? d_imm_i : rs2_byp;
        x_store_data_d = rs2_byp;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_val_q        <= 1'b0;
      x_rf_wen_q     <= 1'b0;
      x_alu_op_q     <= 1'b0;
      x_rd_addr_q    <= 5'd0;
      x_alu_in0_q    <= 32'd0;
      x_alu_in1_q    <= 32'd0;
      x_store_data_q <= 32'd0;
    end else begin
      x_val_q        <= x_val_d;
      x_rf_wen_q     <= x_rf_wen_d;
      x_alu_op_q     <= x_alu_op_d;
      x_rd_addr_q    <= x_rd_addr_d;
      x_alu_in0_q    <= x_alu_in0_d;
      x_alu_in1_q    <= x_alu_in1_d;
      x_store_data_q <= x_store_data_d;
    end
  end

  assign d_rdy_o        = ~x_stall_i;
  assign x_val_o        = x_val_q;
  assign x_rf_wen_o     = x_rf_wen_q;
  assign x_alu_op_o     = x_alu_op_q;
  assign x_rd_addr_o    = x_rd_addr_q;
  assign x_alu_in0_o    = x_alu_in0_q;
  assign x_alu_in1_o    = x_alu_in1_q;
  assign x_store_data_o = x_store_data_q;

endmodule
